// File: rtl/sargantana_icache_pkg.sv
// Shared icache flush-sequencer definitions.
//   ICACHE_N_WAY     : ways per set
//   ICACHE_DEPTH     : sets (power of two, >= 2)
//   ICACHE_IDX_WIDTH : set index width
//   iflush_state_t   : flush sequencer states
package sargantana_icache_pkg;

  localparam int ICACHE_N_WAY     = 4;
  localparam int ICACHE_DEPTH     = 64;
  localparam int ICACHE_IDX_WIDTH = $clog2(ICACHE_DEPTH);

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    DRAIN,
    WALK,
    DONE
  } iflush_state_t;

endpackage

// File: rtl/sargantana_icache_flush_seq.sv
// Instruction-cache tag/valid invalidation sequencer.
// Walks every set and issues an all-ways invalidate on the shared tag-array
// write port. Runs once automatically after reset (the valid RAM has no
// reset) and again on every core flush request, after the icache control
// has drained.
//
// Optional: define ICACHE_FLUSH_LINE_EN to let IDLE forward single-line
// invalidates onto the same write port.
//
// Ports:
//   clk_i, rstn_i        clock, async active-low reset
//   flush_i              flush request (level or pulse)
//   ctrl_idle_i          icache ctrl has nothing outstanding
//   inval_ready_i        tag-array write port free this cycle
//   inval_valid_o        invalidate write request
//   inval_idx_o          set index to invalidate
//   inval_way_o          way mask to invalidate
//   flush_busy_o         blocks new core requests
//   flush_done_o         one-cycle pulse at end of a walk
//   line_inval_req_i     single-line invalidate request
//   line_inval_idx_i     single-line set index
//   line_inval_way_i     single-line way mask
//   line_inval_ack_o     single-line invalidate accepted
module sargantana_icache_flush_seq
  import sargantana_icache_pkg::*;
#(
  parameter int ICACHE_N_WAY     = sargantana_icache_pkg::ICACHE_N_WAY,
  parameter int ICACHE_DEPTH     = sargantana_icache_pkg::ICACHE_DEPTH,
  parameter int ICACHE_IDX_WIDTH = $clog2(ICACHE_DEPTH)
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        flush_i,
  input  logic                        ctrl_idle_i,
  input  logic                        inval_ready_i,
  output logic                        inval_valid_o,
  output logic [ICACHE_IDX_WIDTH-1:0] inval_idx_o,
  output logic [ICACHE_N_WAY-1:0]     inval_way_o,
  output logic                        flush_busy_o,
  output logic                        flush_done_o,
  input  logic                        line_inval_req_i,
  input  logic [ICACHE_IDX_WIDTH-1:0] line_inval_idx_i,
  input  logic [ICACHE_N_WAY-1:0]     line_inval_way_i,
  output logic                        line_inval_ack_o
);

  localparam logic [ICACHE_IDX_WIDTH-1:0] LAST_IDX = ICACHE_IDX_WIDTH'(ICACHE_DEPTH - 1);
  localparam logic [ICACHE_IDX_WIDTH-1:0] IDX_ONE  = ICACHE_IDX_WIDTH'(1);

  iflush_state_t               state_q;
  logic [ICACHE_IDX_WIDTH-1:0] idx_q;
  logic                        pending_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= INIT;
      idx_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      case (state_q)
        // INIT is a walk without the drain; nothing is outstanding after reset.
        INIT, WALK: begin
          // A flush mid-walk may postdate lines already refilled, so it
          // needs a complete second walk.
          if (flush_i) pending_q <= 1'b1;
          if (inval_ready_i) begin
            // Depth is a power of two, so the increment wraps to 0 on the last set.
            idx_q <= idx_q + IDX_ONE;
            if (idx_q == LAST_IDX) state_q <= DONE;
          end
        end
        IDLE: begin
          if (flush_i) state_q <= DRAIN;
        end
        DRAIN: begin
          // flush_i here is absorbed: the walk about to start covers it.
          if (ctrl_idle_i) begin
            state_q <= WALK;
            idx_q   <= '0;
          end
        end
        DONE: begin
          // A flush seen in DONE is folded in directly so it is not left
          // stranded as a stale pending bit in IDLE.
          if (pending_q || flush_i) begin
            state_q   <= DRAIN;
            pending_q <= 1'b0;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  always_comb begin
    inval_valid_o    = 1'b0;
    inval_idx_o      = idx_q;
    inval_way_o      = '1;
    flush_busy_o     = 1'b1;
    flush_done_o     = 1'b0;
    line_inval_ack_o = 1'b0;
    case (state_q)
      // Qualified by rstn_i so the request drops the instant reset asserts,
      // even though the register already sits in INIT.
      INIT, WALK: inval_valid_o = rstn_i;
      IDLE: begin
        flush_busy_o = 1'b0;
`ifdef ICACHE_FLUSH_LINE_EN
        // Flush takes precedence; the line request then stays unacked.
        if (line_inval_req_i && !flush_i) begin
          inval_valid_o    = 1'b1;
          inval_idx_o      = line_inval_idx_i;
          inval_way_o      = line_inval_way_i;
          line_inval_ack_o = inval_ready_i;
        end
`endif
      end
      DONE:    flush_done_o = 1'b1;
      default: ;
    endcase
  end

`ifndef ICACHE_FLUSH_LINE_EN
  logic unused_line_inval;
  assign unused_line_inval = ^{line_inval_req_i, line_inval_idx_i, line_inval_way_i};
`endif

endmodule

// File: tb/tb_sargantana_icache_flush_seq.sv
module tb_sargantana_icache_flush_seq;
  import sargantana_icache_pkg::*;

  localparam int NW    = ICACHE_N_WAY;
  localparam int DEPTH = ICACHE_DEPTH;
  localparam int IW    = ICACHE_IDX_WIDTH;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          flush_i, ctrl_idle_i, inval_ready_i;
  logic          inval_valid_o, flush_busy_o, flush_done_o, line_inval_ack_o;
  logic [IW-1:0] inval_idx_o, line_inval_idx_i;
  logic [NW-1:0] inval_way_o, line_inval_way_i;
  logic          line_inval_req_i;

  int pass_cnt = 0;
  int total    = 0;

  // observations of one walk, filled by collect_walk
  int obs_idx[$];
  int obs_cycles, obs_valid, obs_refused, obs_hold_err, obs_way_err, obs_busy_low;
  bit obs_done;

  always #5 clk_i = ~clk_i;

  sargantana_icache_flush_seq dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .flush_i(flush_i), .ctrl_idle_i(ctrl_idle_i),
    .inval_ready_i(inval_ready_i), .inval_valid_o(inval_valid_o), .inval_idx_o(inval_idx_o),
    .inval_way_o(inval_way_o), .flush_busy_o(flush_busy_o), .flush_done_o(flush_done_o),
    .line_inval_req_i(line_inval_req_i), .line_inval_idx_i(line_inval_idx_i),
    .line_inval_way_i(line_inval_way_i), .line_inval_ack_o(line_inval_ack_o)
  );

  // Reference: every walk must present sets 0..DEPTH-1 exactly once, in order.
  function automatic int seq_error();
    if (obs_idx.size() != DEPTH) return 1000 + obs_idx.size();
    for (int i = 0; i < DEPTH; i++) if (obs_idx[i] != i) return i + 1;
    return 0;
  endfunction

  // Called at posedge+1. Drives ready/flush per cycle, records what the DUT
  // presents at each negedge, stops after the flush_done_o cycle.
  task automatic collect_walk(input int stall_idx, input int stall_len,
                              input int flush_idx, input bit rnd, input int budget);
    int stall_left = 0;
    bit stalled = 0, flushed = 0, prev_hold = 0;
    logic [IW-1:0] prev_idx = '0;
    obs_idx.delete();
    obs_cycles = 0; obs_valid = 0; obs_refused = 0; obs_hold_err = 0;
    obs_way_err = 0; obs_busy_low = 0; obs_done = 0;
    for (int c = 0; c < budget && !obs_done; c++) begin
      if (stall_idx >= 0 && !stalled && inval_valid_o && int'(inval_idx_o) == stall_idx) begin
        stall_left = stall_len; stalled = 1;
      end
      if (stall_left > 0) begin inval_ready_i = 1'b0; stall_left--; end
      else if (rnd) inval_ready_i = ($urandom_range(0, 3) != 0);
      else inval_ready_i = 1'b1;
      if (flush_idx >= 0 && !flushed && inval_valid_o && int'(inval_idx_o) == flush_idx) begin
        flush_i = 1'b1; flushed = 1;
      end else flush_i = 1'b0;
      @(negedge clk_i);
      obs_cycles++;
      if (prev_hold && !(inval_valid_o && inval_idx_o == prev_idx)) obs_hold_err++;
      prev_hold = inval_valid_o && !inval_ready_i;
      prev_idx  = inval_idx_o;
      if (inval_valid_o) begin
        obs_valid++;
        if (inval_way_o !== {NW{1'b1}}) obs_way_err++;
        if (inval_ready_i) obs_idx.push_back(int'(inval_idx_o));
        else obs_refused++;
      end
      if (!flush_busy_o) obs_busy_low++;
      if (flush_done_o) obs_done = 1;
      @(posedge clk_i); #1;
    end
    flush_i = 1'b0; inval_ready_i = 1'b1;
  endtask

  task automatic flush_pulse();
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0; flush_i = 0; ctrl_idle_i = 1; inval_ready_i = 1;
    line_inval_req_i = 0; line_inval_idx_i = '0; line_inval_way_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    total++;
    if ({inval_valid_o, flush_busy_o, flush_done_o, line_inval_ack_o, inval_way_o, inval_idx_o}
        !== {1'b0, 1'b1, 1'b0, 1'b0, {NW{1'b1}}, {IW{1'b0}}})
      $display("FAIL reset_outputs: valid=%b busy=%b done=%b ack=%b way=%h idx=%0d, need 0 1 0 0 all-ones 0",
               inval_valid_o, flush_busy_o, flush_done_o, line_inval_ack_o, inval_way_o, inval_idx_o);
    else pass_cnt++;
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
  endtask

  task automatic test_init_walk();
    collect_walk(-1, 0, -1, 0, 200);
    total++;
    if (seq_error() != 0 || obs_way_err != 0)
      $display("FAIL init_sequence: seq_err=%0d way_err=%0d, need 0 0", seq_error(), obs_way_err);
    else pass_cnt++;
    total++;
    if (!obs_done || obs_cycles != DEPTH + 1 || obs_busy_low != 0)
      $display("FAIL init_latency: done=%b cycles=%0d busy_low=%0d, need 1 %0d 0",
               obs_done, obs_cycles, obs_busy_low, DEPTH + 1);
    else pass_cnt++;
    @(negedge clk_i);
    total++;
    if (flush_busy_o !== 1'b0 || inval_valid_o !== 1'b0 || flush_done_o !== 1'b0)
      $display("FAIL init_idle: busy=%b valid=%b done=%b, need 0 0 0", flush_busy_o, inval_valid_o, flush_done_o);
    else pass_cnt++;
    @(posedge clk_i); #1;
  endtask

  task automatic test_line_inval();
    line_inval_req_i = 1; line_inval_idx_i = IW'(5); line_inval_way_i = NW'(4'b0010);
    inval_ready_i = 1;
    #1;
`ifdef ICACHE_FLUSH_LINE_EN
    total++;
    if ({inval_valid_o, inval_idx_o, inval_way_o, line_inval_ack_o, flush_busy_o}
        !== {1'b1, IW'(5), NW'(4'b0010), 1'b1, 1'b0})
      $display("FAIL line_forward: valid=%b idx=%0d way=%b ack=%b busy=%b, need 1 5 0010 1 0",
               inval_valid_o, inval_idx_o, inval_way_o, line_inval_ack_o, flush_busy_o);
    else pass_cnt++;
    inval_ready_i = 0; #1;
    total++;
    if (line_inval_ack_o !== 1'b0 || inval_valid_o !== 1'b1)
      $display("FAIL line_ack_ready: ack=%b valid=%b, need 0 1", line_inval_ack_o, inval_valid_o);
    else pass_cnt++;
`else
    total++;
    if (inval_valid_o !== 1'b0 || line_inval_ack_o !== 1'b0)
      $display("FAIL line_ignored: valid=%b ack=%b, need 0 0", inval_valid_o, line_inval_ack_o);
    else pass_cnt++;
`endif
    inval_ready_i = 1;
    @(posedge clk_i); #1;
    total++;
    if (flush_busy_o !== 1'b0)
      $display("FAIL line_no_state_change: busy=%b, need 0", flush_busy_o);
    else pass_cnt++;
    flush_i = 1; #1;
    total++;
    if (line_inval_ack_o !== 1'b0)
      $display("FAIL line_vs_flush_ack: ack=%b, need 0", line_inval_ack_o);
    else pass_cnt++;
    @(posedge clk_i); #1;
    flush_i = 0; line_inval_req_i = 0;
    total++;
    if (flush_busy_o !== 1'b1 || inval_valid_o !== 1'b0)
      $display("FAIL line_vs_flush_drain: busy=%b valid=%b, need 1 0", flush_busy_o, inval_valid_o);
    else pass_cnt++;
    collect_walk(-1, 0, -1, 0, 200);
    total++;
    if (seq_error() != 0 || !obs_done || obs_cycles != DEPTH + 2)
      $display("FAIL line_flush_walk: seq_err=%0d done=%b cycles=%0d, need 0 1 %0d",
               seq_error(), obs_done, obs_cycles, DEPTH + 2);
    else pass_cnt++;
  endtask

  task automatic test_flush_drain();
    int bad = 0;
    ctrl_idle_i = 0;
    flush_pulse();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      if (flush_busy_o !== 1'b1 || inval_valid_o !== 1'b0) bad++;
      @(posedge clk_i); #1;
    end
    total++;
    if (bad != 0) $display("FAIL drain_hold: bad_cycles=%0d, need 0", bad);
    else pass_cnt++;
    ctrl_idle_i = 1;
    collect_walk(-1, 0, -1, 0, 200);
    total++;
    if (seq_error() != 0 || !obs_done || obs_cycles != DEPTH + 2 || obs_busy_low != 0 || obs_way_err != 0)
      $display("FAIL drain_walk: seq_err=%0d done=%b cycles=%0d busy_low=%0d way_err=%0d, need 0 1 %0d 0 0",
               seq_error(), obs_done, obs_cycles, obs_busy_low, obs_way_err, DEPTH + 2);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    flush_pulse();
    collect_walk(17, 3, -1, 0, 200);
    total++;
    if (seq_error() != 0 || obs_hold_err != 0)
      $display("FAIL stall_sequence: seq_err=%0d hold_err=%0d, need 0 0", seq_error(), obs_hold_err);
    else pass_cnt++;
    total++;
    if (obs_valid != DEPTH + 3 || obs_cycles != DEPTH + 5 || !obs_done)
      $display("FAIL stall_length: walk=%0d cycles=%0d done=%b, need %0d %0d 1",
               obs_valid, obs_cycles, obs_done, DEPTH + 3, DEPTH + 5);
    else pass_cnt++;
  endtask

  task automatic test_reflush();
    flush_pulse();
    collect_walk(-1, 0, 40, 0, 200);
    total++;
    if (seq_error() != 0 || !obs_done)
      $display("FAIL reflush_first: seq_err=%0d done=%b, need 0 1", seq_error(), obs_done);
    else pass_cnt++;
    collect_walk(-1, 0, -1, 0, 200);
    total++;
    if (seq_error() != 0 || !obs_done || obs_cycles != DEPTH + 2 || obs_busy_low != 0)
      $display("FAIL reflush_second: seq_err=%0d done=%b cycles=%0d busy_low=%0d, need 0 1 %0d 0",
               seq_error(), obs_done, obs_cycles, obs_busy_low, DEPTH + 2);
    else pass_cnt++;
    @(negedge clk_i);
    total++;
    if (flush_busy_o !== 1'b0)
      $display("FAIL reflush_idle: busy=%b, need 0", flush_busy_o);
    else pass_cnt++;
    @(posedge clk_i); #1;
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      int d = $urandom_range(0, 4);
      int bad = 0;
      ctrl_idle_i = 0;
      flush_pulse();
      for (int i = 0; i < d; i++) begin
        flush_i = 1'($urandom_range(0, 1));
        @(negedge clk_i);
        if (flush_busy_o !== 1'b1 || inval_valid_o !== 1'b0) bad++;
        @(posedge clk_i); #1;
      end
      flush_i = 0; ctrl_idle_i = 1;
      collect_walk(-1, 0, -1, 1, 1000);
      total++;
      if (bad != 0 || seq_error() != 0 || obs_hold_err != 0 || obs_busy_low != 0 || !obs_done)
        $display("FAIL random_walk[%0d]: drain_bad=%0d seq_err=%0d hold_err=%0d busy_low=%0d done=%b, need 0 0 0 0 1",
                 it, bad, seq_error(), obs_hold_err, obs_busy_low, obs_done);
      else pass_cnt++;
      total++;
      if (obs_cycles != DEPTH + obs_refused + 2)
        $display("FAIL random_latency[%0d]: cycles=%0d, need %0d", it, obs_cycles, DEPTH + obs_refused + 2);
      else pass_cnt++;
      @(negedge clk_i);
      total++;
      if (flush_busy_o !== 1'b0)
        $display("FAIL random_absorbed[%0d]: busy=%b, need 0", it, flush_busy_o);
      else pass_cnt++;
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_reset_midwalk();
    int n = 0;
    flush_pulse();
    while (!(inval_valid_o && inval_idx_o == IW'(30)) && n < 200) begin
      @(posedge clk_i); #1; n++;
    end
    total++;
    if (n >= 200) $display("FAIL midwalk_reach: idx 30 not reached in %0d cycles, need reached", n);
    else pass_cnt++;
    rstn_i = 1'b0; #1;
    total++;
    if ({inval_valid_o, flush_busy_o, flush_done_o, inval_way_o, inval_idx_o}
        !== {1'b0, 1'b1, 1'b0, {NW{1'b1}}, {IW{1'b0}}})
      $display("FAIL midwalk_reset: valid=%b busy=%b done=%b way=%h idx=%0d, need 0 1 0 all-ones 0",
               inval_valid_o, flush_busy_o, flush_done_o, inval_way_o, inval_idx_o);
    else pass_cnt++;
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
    collect_walk(-1, 0, -1, 0, 200);
    total++;
    if (seq_error() != 0 || !obs_done || obs_cycles != DEPTH + 1)
      $display("FAIL midwalk_restart: seq_err=%0d done=%b cycles=%0d, need 0 1 %0d",
               seq_error(), obs_done, obs_cycles, DEPTH + 1);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_init_walk();
    test_line_inval();
    test_flush_drain();
    test_stall();
    test_reflush();
    test_random();
    test_reset_midwalk();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/sargantana_icache_flush_seq.md
Name: sargantana_icache_flush_seq

Overview:
- Sequences invalidation of the instruction-cache tag/valid array. Runs on fence.i/flush requests and automatically once after reset, because the valid RAM has no reset.
- Walks every set index and asserts an all-ways invalidate on the tag-array write port. It shares that port with the refill path, and refill has priority.
- Sits between the core flush signal, the icache control FSM (drain indication, busy back-pressure) and the tag/valid array.

Parameters:
ICACHE_N_WAY, 4, number of ways (default from shared package)
ICACHE_DEPTH, 64, number of sets; power of two, >= 2
ICACHE_IDX_WIDTH, $clog2(ICACHE_DEPTH), set index width

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
flush_i  in  1  flush request from core; level or pulse, sampled every cycle
ctrl_idle_i  in  1  icache ctrl has no outstanding IFILL and no pending response
inval_ready_i  in  1  tag-array write port free this cycle (low while refill writes)
inval_valid_o  out  1  invalidate write request
inval_idx_o  out  ICACHE_IDX_WIDTH  set index to invalidate
inval_way_o  out  ICACHE_N_WAY  way mask to invalidate
flush_busy_o  out  1  blocks new core requests (forces iresp_ready low)
flush_done_o  out  1  one-cycle pulse when a walk completes
line_inval_req_i  in  1  single-line invalidate request (optional feature)
line_inval_idx_i  in  ICACHE_IDX_WIDTH  single-line set index
line_inval_way_i  in  ICACHE_N_WAY  single-line way mask
line_inval_ack_o  out  1  single-line invalidate accepted

Behaviour:
- States: INIT, IDLE, DRAIN, WALK, DONE.
- Reset: state=INIT, idx counter=0, pending=0. All outputs 0 except flush_busy_o=1 and inval_way_o=all ones.
- INIT: same as WALK but skips DRAIN, since nothing is outstanding after reset. It asserts flush_done_o on completion like a normal walk.
- IDLE: flush_i=1 -> DRAIN. flush_busy_o=0.
- DRAIN: flush_busy_o=1. Waits for ctrl_idle_i=1, then goes to WALK next cycle with idx=0.
- WALK: inval_valid_o=1, inval_idx_o=idx, inval_way_o=all ones, flush_busy_o=1.
  - Transfer when inval_valid_o && inval_ready_i; then idx increments.
  - inval_ready_i=0 -> hold idx and outputs stable.
  - Transfer with idx==ICACHE_DEPTH-1 -> idx wraps to 0, next state DONE.
- DONE: single cycle. flush_done_o=1, flush_busy_o=1. Next state DRAIN if pending=1 (pending then clears), else IDLE.
- pending: set when flush_i=1 in WALK, INIT or DONE; cleared on entering DRAIN from DONE. A flush arriving mid-walk therefore forces a full second walk. flush_i in DRAIN is absorbed.
- Latency:
  - IDLE->done with ctrl_idle_i and inval_ready_i held high: 1 (DRAIN) + ICACHE_DEPTH (WALK) + 1 (DONE) cycles.
  - Post-reset: ICACHE_DEPTH WALK cycles, then DONE.
- inval_valid_o never drops while in WALK without a transfer.
- Asynchronous reset mid-walk restarts at INIT, idx=0.

Optional Feature:
- Macro ICACHE_FLUSH_LINE_EN.
- Defined:
  - In IDLE, line_inval_req_i=1 drives inval_valid_o=1 with inval_idx_o=line_inval_idx_i and inval_way_o=line_inval_way_i, combinationally.
  - line_inval_ack_o=inval_ready_i. flush_busy_o stays 0. No state change.
  - If flush_i and line_inval_req_i are high together, flush wins, the line request is not acked, and IDLE->DRAIN.
- Undefined: line_inval_* inputs ignored; line_inval_ack_o tied 0.

Decomposition:
- sargantana_icache_pkg holds ICACHE_N_WAY, ICACHE_DEPTH, ICACHE_IDX_WIDTH and the typedef iflush_state_t {INIT, IDLE, DRAIN, WALK, DONE}.
- No sub-module: the index counter is inline in a single FSM with registered state/idx/pending and a combinational output block.

Test Plan:
- Reset, then ICACHE_DEPTH=64 and inval_ready_i=1 -> idx 0..63 on 64 consecutive cycles with way mask 4'b1111, then one flush_done_o pulse, state IDLE, flush_busy_o=0.
- flush_i pulse in IDLE with ctrl_idle_i=0 for 5 cycles -> flush_busy_o=1, no inval_valid_o until ctrl_idle_i=1, then walk 0..63 and flush_done_o.
- During walk, inval_ready_i=0 for 3 cycles at idx=17 -> idx 17 and inval_valid_o held 3 cycles, resumes at 18, total walk 67 cycles.
- flush_i at idx=40 -> first walk completes with flush_done_o, then DRAIN and a second full walk 0..63 with a second flush_done_o.
- Reset asserted at idx=30 -> outputs to reset values immediately, INIT walk restarts at idx=0.
- With ICACHE_FLUSH_LINE_EN: in IDLE, line_inval_req_i=1, idx=5, way=4'b0010, inval_ready_i=1 -> inval_valid_o=1, inval_idx_o=5, inval_way_o=4'b0010, ack=1. Same request together with flush_i -> ack=0, DRAIN entered.
